// File: rtl/seq_div_if.sv
// Operand and result streams for the iterative divider: two joined input
// streams (dividend, divisor) and one backpressured result stream.
interface seq_div_if #(
  parameter int unsigned WIDTH = 8
);
  logic             i_a_valid;
  logic             o_a_ready;
  logic [WIDTH-1:0] i_a;
  logic             i_b_valid;
  logic             o_b_ready;
  logic [WIDTH-1:0] i_b;
  logic             o_result_valid;
  logic             i_result_ready;
  logic [WIDTH-1:0] o_quot;
  logic [WIDTH-1:0] o_rem;
  logic             o_dbz;

  modport slave (
    input  i_a_valid, i_a, i_b_valid, i_b, i_result_ready,
    output o_a_ready, o_b_ready, o_result_valid, o_quot, o_rem, o_dbz
  );

  modport master (
    output i_a_valid, i_a, i_b_valid, i_b, i_result_ready,
    input  o_a_ready, o_b_ready, o_result_valid, o_quot, o_rem, o_dbz
  );
endinterface

// File: rtl/seq_div.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, result
// held on a valid/ready stream until the consumer takes it.
module seq_div #(
  parameter int unsigned WIDTH = 8
) (
  input logic     clk,
  input logic     reset,
  seq_div_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic             accept;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  always_comb begin
    accept    = (state_q == StIdle) && bus.i_a_valid && bus.i_b_valid;
    shifted   = {rem_q, quot_q[WIDTH-1]};
    // rem < divisor keeps the true difference within +/-2^WIDTH, so the MSB is the sign.
    trial     = shifted - {1'b0, divisor_q};

    state_d   = state_q;
    cnt_d     = cnt_q;
    divisor_d = divisor_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    dbz_d     = dbz_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          divisor_d = bus.i_b;
          quot_d    = bus.i_a;
          rem_d     = '0;
          cnt_d     = '0;
          dbz_d     = (bus.i_b == '0);
          state_d   = StBusy;
        end
      end
      StBusy: begin
        if (!trial[WIDTH]) begin
          rem_d  = trial[WIDTH-1:0];
          quot_d = {quot_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d  = shifted[WIDTH-1:0];
          quot_d = {quot_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.i_result_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      divisor_q <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      divisor_q <= divisor_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      dbz_q     <= dbz_d;
    end
  end

  assign bus.o_a_ready      = accept;
  assign bus.o_b_ready      = accept;
  assign bus.o_result_valid = (state_q == StDone);
  assign bus.o_quot         = quot_q;
  assign bus.o_rem          = rem_q;
  assign bus.o_dbz          = dbz_q;

endmodule

// File: tb/tb_seq_div.sv
// Bench for seq_div: directed scenarios plus a randomized sweep, all checked
// every cycle against an arithmetic reference model.
module tb_seq_div;

  localparam int unsigned Width = 8;
  localparam int unsigned Bound = 30;

  logic clk = 1'b0;
  logic reset;

  seq_div_if #(.WIDTH(Width)) bus ();

  seq_div #(.WIDTH(Width)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [Width-1:0] quot;
    logic [Width-1:0] rem;
    logic             dbz;
  } res_t;

  function automatic res_t model(input logic [Width-1:0] a, input logic [Width-1:0] b);
    res_t r;
    if (b == '0) begin
      r.quot = '1;
      r.rem  = a;
      r.dbz  = 1'b1;
    end else begin
      r.quot = a / b;
      r.rem  = a % b;
      r.dbz  = 1'b0;
    end
    return r;
  endfunction

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned accepts  = 0;
  int unsigned results  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
  endtask

  // Reference: a result is owed (Width+1) cycles after the accepting cycle and
  // stays on the outputs until taken; no new operands while one is owed.
  res_t exp_q[$];
  time  acc_time = 0;
  bit   armed    = 1'b0;

  always @(negedge clk) begin
    logic exp_ready;
    logic exp_valid;
    exp_ready = (exp_q.size() == 0) && bus.i_a_valid && bus.i_b_valid;
    exp_valid = (exp_q.size() != 0) && (($time - acc_time) >= time'((Width + 1) * 10));
    if (armed) begin
      chk("a_ready", 32'(bus.o_a_ready), 32'(exp_ready));
      chk("b_ready", 32'(bus.o_b_ready), 32'(exp_ready));
      chk("result_valid", 32'(bus.o_result_valid), 32'(exp_valid));
      if (exp_valid) begin
        chk("quot", 32'(bus.o_quot), 32'(exp_q[0].quot));
        chk("rem", 32'(bus.o_rem), 32'(exp_q[0].rem));
        chk("dbz", 32'(bus.o_dbz), 32'(exp_q[0].dbz));
      end
    end
    if (reset) begin
      exp_q.delete();
      armed = 1'b1;
    end else if (armed) begin
      if (exp_ready) begin
        exp_q.push_back(model(bus.i_a, bus.i_b));
        acc_time = $time;
        accepts++;
      end else if (exp_valid && bus.i_result_ready) begin
        void'(exp_q.pop_front());
        results++;
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [Width-1:0] a, input logic [Width-1:0] b,
                      input int lead, input bit lead_a, output time t_acc);
    bit got;
    got = 1'b0;
    t_acc = 0;
    bus.i_a = a;
    bus.i_b = b;
    if (lead > 0) begin
      if (lead_a) bus.i_a_valid = 1'b1;
      else bus.i_b_valid = 1'b1;
      repeat (lead) @(posedge clk);
      #1;
    end
    bus.i_a_valid = 1'b1;
    bus.i_b_valid = 1'b1;
    for (int i = 0; i < int'(Bound); i++) begin
      @(negedge clk);
      if (bus.o_a_ready) begin
        got = 1'b1;
        t_acc = $time;
        break;
      end
    end
    if (!got) chk("accept_timeout", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    bus.i_a_valid = 1'b0;
    bus.i_b_valid = 1'b0;
  endtask

  // Returns at the falling edge where result valid is first seen.
  task automatic wait_valid(output time t_v);
    bit got;
    got = 1'b0;
    t_v = 0;
    for (int i = 0; i < int'(Bound); i++) begin
      @(negedge clk);
      if (bus.o_result_valid) begin
        got = 1'b1;
        t_v = $time;
        break;
      end
    end
    if (!got) chk("valid_timeout", 32'(got), 32'd1);
  endtask

  task automatic expect_result(input string name, input logic [Width-1:0] q,
                               input logic [Width-1:0] r, input logic d);
    chk({name, "_quot"}, 32'(bus.o_quot), 32'(q));
    chk({name, "_rem"}, 32'(bus.o_rem), 32'(r));
    chk({name, "_dbz"}, 32'(bus.o_dbz), 32'(d));
  endtask

  initial begin
    time t_acc;
    time t_v;
    res_t m;
    logic [Width-1:0] a;
    logic [Width-1:0] b;
    int unsigned acc0;
    int unsigned res0;
    bit rr;

    reset              = 1'b1;
    bus.i_a_valid      = 1'b0;
    bus.i_b_valid      = 1'b0;
    bus.i_a            = '0;
    bus.i_b            = '0;
    bus.i_result_ready = 1'b0;

    // Pin the model against hand-computed values.
    m = model(8'd100, 8'd7);
    chk("model_100_7", 32'(m), 32'({8'd14, 8'd2, 1'b0}));
    m = model(8'd5, 8'd0);
    chk("model_5_0", 32'(m), 32'({8'd255, 8'd5, 1'b1}));
    m = model(8'd200, 8'd13);
    chk("model_200_13", 32'(m), 32'({8'd15, 8'd5, 1'b0}));

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(bus.o_result_valid), 32'd0);
    expect_result("rst", 8'd0, 8'd0, 1'b0);
    @(posedge clk);
    #1;

    // Basic division with latency.
    bus.i_result_ready = 1'b1;
    send(8'd100, 8'd7, 0, 1'b0, t_acc);
    wait_valid(t_v);
    chk("lat_100_7", 32'((t_v - t_acc) / 10), 32'd9);
    expect_result("d100_7", 8'd14, 8'd2, 1'b0);
    @(posedge clk);
    #1;

    // Divide by zero, same latency.
    send(8'd5, 8'd0, 0, 1'b0, t_acc);
    wait_valid(t_v);
    chk("lat_5_0", 32'((t_v - t_acc) / 10), 32'd9);
    expect_result("d5_0", 8'd255, 8'd5, 1'b1);
    @(posedge clk);
    #1;

    // Long backpressure with new operands waiting.
    bus.i_result_ready = 1'b0;
    send(8'd255, 8'd1, 0, 1'b0, t_acc);
    wait_valid(t_v);
    @(posedge clk);
    #1;
    bus.i_a       = 8'd3;
    bus.i_b       = 8'd10;
    bus.i_a_valid = 1'b1;
    bus.i_b_valid = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("stall_valid", 32'(bus.o_result_valid), 32'd1);
      chk("stall_no_accept", 32'(bus.o_a_ready), 32'd0);
      expect_result("stall", 8'd255, 8'd0, 1'b0);
    end
    @(posedge clk);
    #1;
    bus.i_result_ready = 1'b1;
    send(8'd3, 8'd10, 0, 1'b0, t_acc);
    wait_valid(t_v);
    expect_result("d3_10", 8'd0, 8'd3, 1'b0);
    @(posedge clk);
    #1;

    // Lone dividend valid must not be accepted.
    bus.i_a       = 8'd42;
    bus.i_b       = 8'd5;
    bus.i_a_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("lone_a_ready", 32'(bus.o_a_ready), 32'd0);
      chk("lone_b_ready", 32'(bus.o_b_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    send(8'd42, 8'd5, 0, 1'b0, t_acc);
    wait_valid(t_v);
    expect_result("d42_5", 8'd8, 8'd2, 1'b0);
    @(posedge clk);
    #1;

    // Reset during the fourth busy cycle drops the in-flight result.
    send(8'd77, 8'd3, 0, 1'b0, t_acc);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 32'(bus.o_result_valid), 32'd0);
    expect_result("midrst", 8'd0, 8'd0, 1'b0);
    repeat (Width + 4) begin
      @(negedge clk);
      chk("no_stale", 32'(bus.o_result_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    send(8'd200, 8'd13, 0, 1'b0, t_acc);
    wait_valid(t_v);
    expect_result("d200_13", 8'd15, 8'd5, 1'b0);
    @(posedge clk);
    #1;

    // Random sweep with lone-valid leads and result stalls.
    acc0 = accepts;
    res0 = results;
    for (int n = 0; n < 1000; n++) begin
      case ($urandom_range(0, 4))
        0: begin a = Width'($urandom); b = '0; end
        1: begin a = Width'($urandom); b = a; end
        2: begin
          b = Width'($urandom_range(1, 255));
          a = Width'($urandom_range(0, int'(b) - 1));
        end
        default: begin a = Width'($urandom); b = Width'($urandom); end
      endcase
      rr = 1'($urandom_range(0, 1));
      bus.i_result_ready = rr;
      send(a, b, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
           1'($urandom_range(0, 1)), t_acc);
      wait_valid(t_v);
      if (!rr) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
        bus.i_result_ready = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    bus.i_result_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("sweep_accepts", accepts - acc0, 32'd1000);
    chk("sweep_pairs_eq_results", results - res0, accepts - acc0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
